// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the dual-clock FIFO pointer blocks (read-side
//   pointer/empty and write-side pointer/full).
//
//   Contents:
//     FIFO_ASIZE          default address width (depth = 2**FIFO_ASIZE)
//     FIFO_AEMPTY_THRESH  default almost-empty threshold
//     PTR_MAX_W           width of the generic pointer word used by the
//                         Gray helpers
//     bin2gray()          binary -> Gray conversion
//     gray2bin()          Gray -> binary conversion (XOR prefix from MSB down)
//
//   The helpers work on a fixed-width word so one copy serves every ASIZE.
//   Callers zero-extend their ASIZE+1 bit pointer into the word and keep the
//   low ASIZE+1 bits of the result. Leading zeros do not change the low bits
//   in either direction.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_ASIZE         = 4;
    localparam int FIFO_AEMPTY_THRESH = 2;
    localparam int PTR_MAX_W          = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return (b >> 1) ^ b;
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rptr_empty.sv
// -----------------------------------------------------------------------------
// fifo_rptr_empty
//   Read-side pointer and status block of the dual-clock FIFO. Everything in
//   here runs on rclk. The write pointer arrives already synchronized (Gray).
//
//   Parameters:
//     ASIZE          address width, depth = 2**ASIZE (ASIZE <= 30)
//     AEMPTY_THRESH  ralmost_empty when level <= this value (0..2**ASIZE)
//
//   Ports:
//     rclk           read clock
//     rrst_n         synchronous active-low reset
//     rinc           read request, pops one entry when not empty
//     rq2_wptr       synchronized Gray write pointer (ASIZE+1)
//     raddr          binary read address to the memory (ASIZE)
//     rptr           registered Gray read pointer to the r2w synchronizer
//     rempty         registered empty flag
//     ralmost_empty  registered level <= AEMPTY_THRESH
//     rlevel         registered fill level seen from the read side
//     runderflow     one-cycle pulse for a read attempted while empty
// -----------------------------------------------------------------------------
module fifo_rptr_empty
    import fifo_pkg::*;
#(
    parameter int ASIZE         = FIFO_ASIZE,
    parameter int AEMPTY_THRESH = FIFO_AEMPTY_THRESH
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rinc,
    input  logic [ASIZE:0]   rq2_wptr,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   rptr,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   rlevel,
    output logic             runderflow
);

    localparam int PW = ASIZE + 1;

    typedef logic [ASIZE:0] ptr_t;

    localparam ptr_t THRESH = ptr_t'(AEMPTY_THRESH);

    ptr_t      rbin;
    ptr_t      rbinnext;
    ptr_t      rgraynext;
    ptr_t      rwbin;
    ptr_t      rlevelnext;
    logic      rpop;
    ptr_word_t graynext_w;
    ptr_word_t wbin_w;
    logic      unused_hi;

    // Next-state pointer arithmetic. The level is taken against the *next*
    // read pointer so a pop and a write-pointer advance in the same cycle
    // both land in one registered result.
    always_comb begin
        rpop       = rinc & ~rempty;
        rbinnext   = rbin + ptr_t'(rpop);
        graynext_w = bin2gray(ptr_word_t'(rbinnext));
        rgraynext  = graynext_w[ASIZE:0];
        wbin_w     = gray2bin(ptr_word_t'(rq2_wptr));
        rwbin      = wbin_w[ASIZE:0];
        // Modulo 2**(ASIZE+1) subtraction; the extra MSB keeps full (level
        // = 2**ASIZE) distinct from empty.
        rlevelnext = rwbin - rbinnext;
    end

    // Upper bits of the generic helper words are always zero here.
    assign unused_hi = ^{graynext_w[PTR_MAX_W-1:PW], wbin_w[PTR_MAX_W-1:PW]};

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin          <= '0;
            rptr          <= '0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            rlevel        <= '0;
            runderflow    <= 1'b0;
        end else begin
            rbin          <= rbinnext;
            rptr          <= rgraynext;
            rempty        <= (rgraynext == rq2_wptr);
            ralmost_empty <= (rlevelnext <= THRESH);
            rlevel        <= rlevelnext;
            runderflow    <= rinc & rempty;
        end
    end

    assign raddr = rbin[ASIZE-1:0];

endmodule

// File: tb/tb_fifo_rptr_empty.sv
module tb_fifo_rptr_empty;

    localparam int ASIZE = 4;

    logic             rclk;
    logic             rrst_n;
    logic             rinc;
    logic [ASIZE:0]   rq2_wptr;
    logic [ASIZE-1:0] raddr;
    logic [ASIZE:0]   rptr;
    logic             rempty;
    logic             ralmost_empty;
    logic [ASIZE:0]   rlevel;
    logic             runderflow;

    int n_asserts = 0;
    int n_fail    = 0;

    fifo_rptr_empty #(.ASIZE(ASIZE), .AEMPTY_THRESH(2)) dut (
        .rclk          (rclk),
        .rrst_n        (rrst_n),
        .rinc          (rinc),
        .rq2_wptr      (rq2_wptr),
        .raddr         (raddr),
        .rptr          (rptr),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .rlevel        (rlevel),
        .runderflow    (runderflow)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // Bitwise Gray encoding: g[i] = b[i] ^ b[i+1], MSB passes through.
    function automatic logic [ASIZE:0] gray(input logic [ASIZE:0] b);
        logic [ASIZE:0] g;
        g[ASIZE] = b[ASIZE];
        for (int i = 0; i < ASIZE; i++) g[i] = b[i] ^ b[i+1];
        return g;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit after it.
    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [ASIZE-1:0] e_addr,
                             input logic [ASIZE:0] e_ptr, input logic e_empty,
                             input logic e_ae, input logic [ASIZE:0] e_lvl,
                             input logic e_uf);
        check({tag, ".raddr"},  32'(raddr),         32'(e_addr));
        check({tag, ".rptr"},   32'(rptr),          32'(e_ptr));
        check({tag, ".rempty"}, 32'(rempty),        32'(e_empty));
        check({tag, ".ae"},     32'(ralmost_empty), 32'(e_ae));
        check({tag, ".rlevel"}, 32'(rlevel),        32'(e_lvl));
        check({tag, ".uf"},     32'(runderflow),    32'(e_uf));
    endtask

    logic [ASIZE:0] eb;
    logic [ASIZE:0] wb;

    initial begin
        // ---------------- reset with rinc high ----------------
        rrst_n   = 1'b0;
        rinc     = 1'b1;
        rq2_wptr = 5'b00010;
        tick(); tick(); tick();
        check_all("reset", 4'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);

        rrst_n = 1'b1;
        rinc   = 1'b0;
        tick();
        check_all("release", 4'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0);

        // ---------------- drain 3 entries then underflow ----------------
        rinc = 1'b1;
        tick();
        check_all("drain1", 4'd1, 5'b00001, 1'b0, 1'b1, 5'd2, 1'b0);
        tick();
        check_all("drain2", 4'd2, 5'b00011, 1'b0, 1'b1, 5'd1, 1'b0);
        tick();
        check_all("drain3", 4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b0);
        tick();
        check_all("drain4", 4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b1);
        rinc = 1'b0;
        tick();
        check_all("uf_clear", 4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b0);

        // ---------------- full level ----------------
        rrst_n = 1'b0;
        tick();
        rrst_n   = 1'b1;
        rq2_wptr = 5'b11000;
        tick();
        check_all("full", 4'd0, 5'd0, 1'b0, 1'b0, 5'd16, 1'b0);
        rinc = 1'b1;
        tick();
        check_all("full_pop", 4'd1, 5'b00001, 1'b0, 1'b0, 5'd15, 1'b0);
        rinc = 1'b0;

        // ---------------- wrap: 40 pops, write 4 ahead ----------------
        rrst_n = 1'b0;
        tick();
        rrst_n   = 1'b1;
        eb       = '0;
        wb       = 5'd4;
        rq2_wptr = gray(wb);
        tick();
        check_all("wrap_start", 4'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b0);
        for (int n = 0; n < 40; n++) begin
            rinc     = 1'b1;
            wb       = wb + 5'd1;
            rq2_wptr = gray(wb);
            tick();
            eb = eb + 5'd1;
            check_all("wrap", eb[ASIZE-1:0], gray(eb), 1'b0, 1'b0, 5'd4, 1'b0);
            if (eb == 5'd31) check("wrap_ptr31", 32'(rptr), 32'b10000);
            if (eb == 5'd0)  check("wrap_ptr0",  32'(rptr), 32'b00000);
        end

        // ---------------- simultaneous pop and write advance ----------------
        // eb = 8, wb = 12 here.
        rinc     = 1'b0;
        wb       = wb + 5'd1;
        rq2_wptr = gray(wb);
        tick();
        check_all("sim_pre", 4'd8, gray(5'd8), 1'b0, 1'b0, 5'd5, 1'b0);
        rinc     = 1'b1;
        wb       = wb + 5'd1;
        rq2_wptr = gray(wb);
        tick();
        check_all("sim", 4'd9, gray(5'd9), 1'b0, 1'b0, 5'd5, 1'b0);

        // ---------------- reset mid-drain ----------------
        rinc     = 1'b0;
        wb       = 5'd16;
        rq2_wptr = gray(wb);
        tick();
        check_all("mid_pre", 4'd9, gray(5'd9), 1'b0, 1'b0, 5'd7, 1'b0);
        rrst_n = 1'b0;
        rinc   = 1'b1;
        tick();
        check_all("mid_rst", 4'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
        tick();
        check_all("mid_rst2", 4'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rptr_empty.md
Name: fifo_rptr_empty

Overview:
- Read-side pointer and status block of the dual-clock FIFO, living entirely in the read clock domain.
- Consumes the write pointer after it has passed through the two-stage write-to-read synchronizer (rq2_wptr, Gray coded).
- Maintains the binary read address and the Gray read pointer that is exported to the read-to-write synchronizer.
- Generates registered empty, almost-empty, fill-level and underflow indications for the reading logic.

Parameters:
- ASIZE, 4: address width; FIFO depth = 2**ASIZE; pointers are ASIZE+1 bits, with the extra MSB used for wrap detection.
- AEMPTY_THRESH, 2: ralmost_empty asserts when the fill level is less than or equal to this value; legal range 0..2**ASIZE.

Ports:
- rclk  input  1  read-domain clock; all state updates on the rising edge.
- rrst_n  input  1  synchronous, active-low reset, sampled on rising rclk.
- rinc  input  1  read request; pops one entry when rempty=0.
- rq2_wptr  input  ASIZE+1  synchronized Gray write pointer.
- raddr  output  ASIZE  binary read address to the FIFO memory, equal to the low ASIZE bits of the binary read pointer.
- rptr  output  ASIZE+1  registered Gray read pointer, sent to the read-to-write synchronizer.
- rempty  output  1  registered empty flag.
- ralmost_empty  output  1  registered, level <= AEMPTY_THRESH.
- rlevel  output  ASIZE+1  registered fill level as seen from the read domain, range 0..2**ASIZE.
- runderflow  output  1  one-cycle pulse when rinc is asserted while rempty=1.

Behaviour:
- Reset (rrst_n=0 at an edge):
  - rbin=0, rptr=0, rempty=1, ralmost_empty=1, rlevel=0, runderflow=0.
  - rinc is ignored during reset.
  - A reset in mid-operation returns every register to these values on that edge, regardless of rinc or rq2_wptr.
- Pop qualification: rpop = rinc & ~rempty.
- Next-pointer computation:
  - rbinnext = rbin + rpop, modulo 2**(ASIZE+1); it wraps from all-ones to 0.
  - rgraynext = (rbinnext >> 1) ^ rbinnext.
- Register updates each non-reset edge:
  - rbin <= rbinnext.
  - rptr <= rgraynext.
  - rempty <= (rgraynext == rq2_wptr).
  - rlevel <= gray2bin(rq2_wptr) - rbinnext, modulo 2**(ASIZE+1).
  - ralmost_empty <= (that same next level <= AEMPTY_THRESH).
  - runderflow <= rinc & rempty.
- raddr is rbin[ASIZE-1:0] driven combinationally from the register, so it carries no extra latency.
- Latency:
  - A pop updates raddr, rptr, rlevel and rempty on the same edge.
  - A change on rq2_wptr is reflected in rempty, rlevel and ralmost_empty one rclk edge later.
- Pessimism: rempty and rlevel are conservative because the write pointer arrives late through the synchronizer. The FIFO never reports data that is not present; a stale pointer can only make it report fewer entries.
- A read while empty:
  - Pointer unchanged.
  - runderflow asserted for exactly one cycle per offending cycle.
  - Not sticky.
- Simultaneous pop and write-pointer advance: both are applied in the same computation; rlevel reflects the net change.
- Full case: rlevel = 2**ASIZE is legal and reported with rempty=0. The MSB differs between the pointers while all lower bits are equal.
- No state machine; the block is pointer arithmetic plus registered flags. The total state is rbin, rptr, rempty, ralmost_empty, rlevel and runderflow.

Decomposition:
- Package fifo_pkg holds:
  - function bin2gray(ASIZE+1 bits);
  - function gray2bin(ASIZE+1 bits, XOR prefix from the MSB down);
  - the default constants for ASIZE and AEMPTY_THRESH.
  - These are shared with the write-side pointer/full block, which mirrors this one.
- No sub-module; the Gray conversion is a package function.

Test Plan (all cases ASIZE=4, AEMPTY_THRESH=2):
- Reset: rrst_n=0 for 3 edges with rinc=1 and rq2_wptr=5'b00010 -> rempty=1, ralmost_empty=1, rptr=0, raddr=0, rlevel=0, runderflow=0. First edge after release -> rempty=0, rlevel=3, ralmost_empty=0.
- Drain: from rlevel=3 with rq2_wptr held at gray(3)=00010, rinc=1 for 4 cycles:
  - raddr goes 1, 2, 3 and then holds at 3;
  - rlevel goes 2, 1, 0;
  - ralmost_empty=1 from the first pop edge;
  - rempty=1 on the third pop edge;
  - runderflow pulses on the 4th cycle only.
- Full level: rbin=0 and rq2_wptr=gray(16)=5'b11000 -> rlevel=16, rempty=0. A single pop gives rlevel=15 and rptr=5'b00001.
- Wrap: stream 40 entries, keeping rq2_wptr 4 ahead and popping every cycle. rbin passes 31->0 with rptr going 5'b10000->5'b00000, and there is no false rempty or underflow across the wrap.
- Simultaneous events: rlevel=5, then one pop and rq2_wptr advancing by 1 in the same cycle -> rlevel stays 5 and raddr increments by 1.
- Reset mid-drain: assert rrst_n=0 while rlevel=7 and rinc=1 -> on the next edge all outputs return to their reset values, and no underflow pulse is produced.
